// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command bus arbiter: holds the pins on sdram_init until init_end,
// then grants the bus to refresh, write or read (fixed priority) one at a time.
module sdram_cmd_arbiter #(
    parameter int          ADDR_W  = 11,
    parameter int          DATA_W  = 16,
    parameter logic [3:0]  NOP_CMD = 4'b0111
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_end,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARBIT = 3'd1;
    localparam logic [2:0] AREF  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    logic [2:0] state, next_state;
    logic [3:0] cmd;

    // Grants are registered from next_state so each one tracks its state exactly.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
        end else begin
            state     <= next_state;
            aref_en   <= (next_state == AREF);
            wr_en     <= (next_state == WRITE);
            rd_en     <= (next_state == READ);
            sdram_cke <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (init_end) next_state = ARBIT;
            ARBIT: begin
                if (aref_req)    next_state = AREF;
                else if (wr_req) next_state = WRITE;
                else if (rd_req) next_state = READ;
            end
            AREF:    if (aref_end) next_state = ARBIT;
            WRITE:   if (wr_end)   next_state = ARBIT;
            READ:    if (rd_end)   next_state = ARBIT;
            default: next_state = IDLE;
        endcase
    end

    // Pins are idle while reset is held, even though state already reads IDLE.
    always_comb begin
        cmd          = NOP_CMD;
        sdram_ba     = 2'b11;
        sdram_addr   = '1;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        if (sys_rst_n) begin
            case (state)
                IDLE: begin
                    cmd        = init_cmd;
                    sdram_ba   = init_ba;
                    sdram_addr = init_addr;
                end
                AREF: begin
                    cmd        = aref_cmd;
                    sdram_ba   = aref_ba;
                    sdram_addr = aref_addr;
                end
                WRITE: begin
                    cmd          = wr_cmd;
                    sdram_ba     = wr_ba;
                    sdram_addr   = wr_addr;
                    sdram_dq_out = wr_data;
                    sdram_dq_oe  = wr_sdram_en;
                end
                READ: begin
                    cmd        = rd_cmd;
                    sdram_ba   = rd_ba;
                    sdram_addr = rd_addr;
                end
                default: ;
            endcase
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule
